// File: rtl/spi_cmd_master.sv
// SPI mode-0 master that runs one 2-byte register-access transaction per accepted
// request: a command byte {wr, hi, addr}, then write data (0x00 on reads) while capturing MISO.
module spi_cmd_master #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic       req_hi,
  input  logic [5:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic       cs_n,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    DONE
  } state_t;

  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  state_t         state;
  state_t         state_next;
  logic [CW-1:0]  cnt;
  logic [DW-1:0]  div_cnt;
  logic [3:0]     bit_cnt;
  logic [15:0]    tx;
  logic [7:0]     rx;
  logic           wr;

  logic accept;
  logic div_tc;
  logic setup_done;
  logic hold_done;
  logic last_fall;

  assign accept     = req_valid & req_ready;
  assign div_tc     = (div_cnt == DW'(CLK_DIV - 1));
  assign setup_done = (cnt == CW'(CS_SETUP - 1));
  assign hold_done  = (cnt == CW'(CS_HOLD - 1));
  assign last_fall  = div_tc & sclk & (bit_cnt == 4'd15);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)     state_next = SETUP;
      SETUP:   if (setup_done) state_next = SHIFT;
      SHIFT:   if (last_fall)  state_next = HOLD;
      HOLD:    if (hold_done)  state_next = DONE;
      DONE:                    state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // Outputs decode straight from state so an async reset releases cs_n in the same cycle.
  always_comb begin
    req_ready = 1'b0;
    busy      = 1'b1;
    cs_n      = 1'b1;
    rsp_valid = 1'b0;
    mosi      = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      SETUP, SHIFT, HOLD: begin
        cs_n = 1'b0;
        mosi = tx[15];
      end
      DONE:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      sclk      <= 1'b0;
      tx        <= '0;
      rx        <= '0;
      wr        <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            tx      <= {req_write, req_hi, req_addr, (req_write ? req_wdata : 8'h00)};
            wr      <= req_write;
            rx      <= '0;
            cnt     <= '0;
            div_cnt <= '0;
            bit_cnt <= '0;
            sclk    <= 1'b0;
          end
        end
        SETUP: cnt <= setup_done ? '0 : cnt + CW'(1);
        SHIFT: begin
          if (div_tc) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
            if (!sclk) begin
              rx <= {rx[6:0], miso};
            end else begin
              tx      <= {tx[14:0], 1'b0};
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        HOLD: begin
          cnt <= hold_done ? '0 : cnt + CW'(1);
          if (hold_done) begin
            rsp_rdata <= wr ? 8'h00 : rx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_master.sv
// Directed bench for spi_cmd_master: default-timing instance plus a CLK_DIV=1 instance,
// each with a behavioural mode-0 slave that returns a programmed byte during byte 1.
module tb_spi_cmd_master;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // default-parameter instance
  logic       req_valid, req_ready, req_write, req_hi;
  logic [5:0] req_addr;
  logic [7:0] req_wdata, rsp_rdata;
  logic       rsp_valid, busy, cs_n, sclk, mosi, miso;

  spi_cmd_master u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_hi(req_hi),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .cs_n(cs_n), .sclk(sclk), .mosi(mosi), .miso(miso)
  );

  // fastest-timing instance
  logic       f_req_valid, f_req_ready, f_req_write, f_req_hi;
  logic [5:0] f_req_addr;
  logic [7:0] f_req_wdata, f_rsp_rdata;
  logic       f_rsp_valid, f_busy, f_cs_n, f_sclk, f_mosi, f_miso;

  spi_cmd_master #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1)) u_fast (
    .clk(clk), .rst_n(rst_n),
    .req_valid(f_req_valid), .req_ready(f_req_ready), .req_write(f_req_write),
    .req_hi(f_req_hi), .req_addr(f_req_addr), .req_wdata(f_req_wdata),
    .rsp_valid(f_rsp_valid), .rsp_rdata(f_rsp_rdata), .busy(f_busy),
    .cs_n(f_cs_n), .sclk(f_sclk), .mosi(f_mosi), .miso(f_miso)
  );

  // Slave models: MOSI is sampled on sclk rising; MISO presents slave_word MSB first,
  // indexed by rising edges seen since cs_n fell.
  logic [15:0] mosi_sr = '0, f_mosi_sr = '0;
  logic [15:0] slave_word = '0, f_slave_word = '0;
  int nbits = 0, start_bits = 0, idx;
  int f_nbits = 0, f_start_bits = 0, f_idx;

  always @(posedge sclk) begin
    mosi_sr <= {mosi_sr[14:0], mosi};
    nbits   <= nbits + 1;
  end
  always @(negedge cs_n) start_bits <= nbits;
  always_comb begin
    miso = 1'b0;
    idx  = nbits - start_bits;
    if (idx >= 0 && idx < 16) miso = slave_word[4'(15 - idx)];
  end

  always @(posedge f_sclk) begin
    f_mosi_sr <= {f_mosi_sr[14:0], f_mosi};
    f_nbits   <= f_nbits + 1;
  end
  always @(negedge f_cs_n) f_start_bits <= f_nbits;
  always_comb begin
    f_miso = 1'b0;
    f_idx  = f_nbits - f_start_bits;
    if (f_idx >= 0 && f_idx < 16) f_miso = f_slave_word[4'(15 - f_idx)];
  end

  // Issue one request on the default instance and wait (bounded) for rsp_valid.
  // lat counts cycles after the accept cycle; lowc counts cs_n-low cycles before rsp_valid.
  task automatic run_txn(input logic w, input logic hi, input logic [5:0] a,
                         input logic [7:0] wd, output logic [7:0] rd,
                         output int lat, output int lowc, output int bits);
    int b0;
    @(negedge clk);
    req_write = w; req_hi = hi; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    b0 = nbits;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL txn_ready: got %b expected 1", req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1; lowc = 0;
    while (rsp_valid !== 1'b1 && lat < 2000) begin
      if (cs_n === 1'b0) lowc++;
      @(negedge clk);
      lat++;
    end
    rd   = rsp_rdata;
    bits = nbits - b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_hi = 1'b0; req_addr = '0; req_wdata = '0;
    f_req_valid = 1'b0; f_req_write = 1'b0; f_req_hi = 1'b0; f_req_addr = '0; f_req_wdata = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({cs_n, sclk, mosi, rsp_valid, busy, req_ready} !== 6'b100001) begin
      n_fail++;
      $display("FAIL reset_ctrl: {cs_n,sclk,mosi,rsp_valid,busy,req_ready}=%b expected 100001",
               {cs_n, sclk, mosi, rsp_valid, busy, req_ready});
    end
    n_checks++;
    if (rsp_rdata !== 8'h00) begin
      n_fail++; $display("FAIL reset_rdata: got %h expected 00", rsp_rdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_hi();
    logic [7:0] rd; int lat, lowc, bits;
    slave_word = 16'h005A;
    run_txn(1'b1, 1'b1, 6'h05, 8'hA5, rd, lat, lowc, bits);
    n_checks++;
    if (mosi_sr !== 16'hC5A5) begin n_fail++; $display("FAIL wr_mosi: got %h expected c5a5", mosi_sr); end
    n_checks++;
    if (rd !== 8'h00) begin n_fail++; $display("FAIL wr_rdata: got %h expected 00", rd); end
    n_checks++;
    if (lat != 133) begin n_fail++; $display("FAIL wr_latency: got %0d expected 133", lat); end
    n_checks++;
    if (lowc != 132) begin n_fail++; $display("FAIL wr_cs_low: got %0d expected 132", lowc); end
    n_checks++;
    if (bits != 16) begin n_fail++; $display("FAIL wr_bits: got %0d expected 16", bits); end
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 8'h00) begin
      n_fail++; $display("FAIL wr_pulse: rsp_valid=%b rdata=%h expected 0/00", rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_read_lo();
    logic [7:0] rd; int lat, lowc, bits;
    slave_word = 16'h003C;
    run_txn(1'b0, 1'b0, 6'h12, 8'hFF, rd, lat, lowc, bits);
    n_checks++;
    if (mosi_sr !== 16'h1200) begin n_fail++; $display("FAIL rd_mosi: got %h expected 1200", mosi_sr); end
    n_checks++;
    if (rd !== 8'h3C) begin n_fail++; $display("FAIL rd_rdata: got %h expected 3c", rd); end
    repeat (3) @(negedge clk);
    n_checks++;
    if (rsp_rdata !== 8'h3C) begin n_fail++; $display("FAIL rd_hold: got %h expected 3c", rsp_rdata); end
  endtask

  task automatic test_back_to_back();
    int n;
    slave_word = 16'h0081;
    @(negedge clk);
    req_write = 1'b1; req_hi = 1'b0; req_addr = 6'h0A; req_wdata = 8'h11; req_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (rsp_valid !== 1'b1 && n < 2000);
    n_checks++;
    if (mosi_sr !== 16'h8A11) begin n_fail++; $display("FAIL b2b_first_mosi: got %h expected 8a11", mosi_sr); end
    n_checks++;
    if (req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_done: got %b expected 0", req_ready); end
    req_write = 1'b0; req_hi = 1'b1; req_addr = 6'h21; req_wdata = 8'hEE;
    @(negedge clk);
    n_checks++;
    if (cs_n !== 1'b1 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_gap: cs_n=%b req_ready=%b expected 1/1", cs_n, req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0;
    n_checks++;
    if (cs_n !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL b2b_second_start: cs_n=%b busy=%b expected 0/1", cs_n, busy);
    end
    n = 0;
    while (rsp_valid !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    n_checks++;
    if (mosi_sr !== 16'h6100) begin n_fail++; $display("FAIL b2b_second_mosi: got %h expected 6100", mosi_sr); end
    n_checks++;
    if (rsp_rdata !== 8'h81) begin n_fail++; $display("FAIL b2b_second_rdata: got %h expected 81", rsp_rdata); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] rd; int lat, lowc, bits, b0, n, seen;
    slave_word = 16'h0000;
    @(negedge clk);
    req_write = 1'b1; req_hi = 1'b0; req_addr = 6'h01; req_wdata = 8'hFF; req_valid = 1'b1;
    b0 = nbits;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while ((nbits - b0) < 9 && n < 2000) begin @(negedge clk); n++; end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({cs_n, sclk, mosi, busy} !== 4'b1000) begin
      n_fail++; $display("FAIL rst_mid_outputs: {cs_n,sclk,mosi,busy}=%b expected 1000", {cs_n, sclk, mosi, busy});
    end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 4) rst_n = 1'b1;
      if (rsp_valid === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin n_fail++; $display("FAIL rst_mid_no_rsp: got %0d pulses expected 0", seen); end
    slave_word = 16'h00E7;
    run_txn(1'b0, 1'b0, 6'h2A, 8'h00, rd, lat, lowc, bits);
    n_checks++;
    if (mosi_sr !== 16'h2A00 || rd !== 8'hE7 || lat != 133) begin
      n_fail++; $display("FAIL rst_mid_recover: mosi=%h rdata=%h lat=%0d expected 2a00/e7/133", mosi_sr, rd, lat);
    end
  endtask

  task automatic test_ignore_busy();
    int lat, lows;
    slave_word = 16'h0055;
    @(negedge clk);
    req_write = 1'b1; req_hi = 1'b0; req_addr = 6'h33; req_wdata = 8'h5C; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    repeat (20) begin @(negedge clk); lat++; end
    req_valid = 1'b1; req_write = 1'b0; req_hi = 1'b1; req_addr = 6'h0F; req_wdata = 8'h00;
    n_checks++;
    if (req_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL busy_ready: req_ready=%b busy=%b expected 0/1", req_ready, busy);
    end
    @(negedge clk); lat++;
    req_valid = 1'b0;
    while (rsp_valid !== 1'b1 && lat < 2000) begin @(negedge clk); lat++; end
    n_checks++;
    if (mosi_sr !== 16'hB35C || rsp_rdata !== 8'h00 || lat != 133) begin
      n_fail++; $display("FAIL busy_txn: mosi=%h rdata=%h lat=%0d expected b35c/00/133", mosi_sr, rsp_rdata, lat);
    end
    lows = 0;
    repeat (4) begin @(negedge clk); if (cs_n !== 1'b1) lows++; end
    n_checks++;
    if (lows != 0) begin n_fail++; $display("FAIL busy_no_queue: %0d cs_n-low cycles expected 0", lows); end
  endtask

  task automatic test_fast();
    int lat, lowc, toggles, highs;
    logic prev;
    f_slave_word = 16'h0096;
    @(negedge clk);
    f_req_write = 1'b0; f_req_hi = 1'b1; f_req_addr = 6'h3F; f_req_wdata = 8'hAA; f_req_valid = 1'b1;
    prev = f_sclk;
    @(negedge clk);
    f_req_valid = 1'b0;
    lat = 1; lowc = 0; toggles = 0; highs = 0;
    while (f_rsp_valid !== 1'b1 && lat < 2000) begin
      if (f_cs_n === 1'b0) lowc++;
      if (f_sclk !== prev) toggles++;
      if (f_sclk === 1'b1) highs++;
      prev = f_sclk;
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (f_mosi_sr !== 16'h7F00) begin n_fail++; $display("FAIL fast_mosi: got %h expected 7f00", f_mosi_sr); end
    n_checks++;
    if (lowc != 34 || lat != 35) begin
      n_fail++; $display("FAIL fast_timing: cs_low=%0d lat=%0d expected 34/35", lowc, lat);
    end
    n_checks++;
    if (toggles != 32 || highs != 16) begin
      n_fail++; $display("FAIL fast_sclk: toggles=%0d highs=%0d expected 32/16", toggles, highs);
    end
    n_checks++;
    if (f_rsp_rdata !== 8'h96) begin n_fail++; $display("FAIL fast_rdata: got %h expected 96", f_rsp_rdata); end
  endtask

  initial begin
    test_reset();
    test_write_hi();
    test_read_lo();
    test_back_to_back();
    test_reset_mid();
    test_ignore_busy();
    test_fast();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
